tcdm_synch_tracker: RTL and testbench

Completion-side tracker for the TCDM unit. It consumes the paired-completion pulses (synch_req/synch_sid) produced when both TCDM ports have retired a sub-transfer. For every transaction SID it counts issued-but-unretired sub-transfers, and pulses a per-SID done flag once the transfer is closed and fully drained. It sits between the TCDM command issue logic (upstream) and the transaction/event unit (downstream).

---
 rtl/tcdm_synch_tracker.sv | 120 ++++++++++++
 tb/tb_tcdm_synch_tracker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_synch_tracker.sv
// Completion-side tracker for the TCDM unit. Counts issued-but-unretired
// sub-transfers per transaction SID and pulses a per-SID done flag once a
// transfer has been closed by its last issue and fully drained by synch pulses.
module tcdm_synch_tracker #(
  parameter int TRANS_SID_WIDTH = 2,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] issue_sid_i,
  input  logic                       issue_last_i,
  output logic                       issue_gnt_o,
  input  logic                       synch_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] synch_sid_i,
  output logic [(2**TRANS_SID_WIDTH)-1:0] trans_done_o,
  output logic [(2**TRANS_SID_WIDTH)-1:0] busy_o,
  output logic                       err_o,
  output logic [TRANS_SID_WIDTH-1:0] err_sid_o,
  input  logic                       clear_err_i
);

  localparam int NB_SID = 2**TRANS_SID_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_CLOSED = 2'd2
  } sid_state_e;

  sid_state_e                 state_q [NB_SID];
  sid_state_e                 state_d [NB_SID];
  logic [CNT_WIDTH-1:0]       cnt_q   [NB_SID];
  logic [CNT_WIDTH-1:0]       cnt_d   [NB_SID];
  logic [NB_SID-1:0]          done_q, done_d;
  logic                       err_q, err_d;
  logic [TRANS_SID_WIDTH-1:0] err_sid_q, err_sid_d;

  logic issue_acc;
  logic underflow;

  // Grant is purely a function of the addressed SID's registered state.
  assign issue_acc = issue_gnt_o;
  assign underflow = synch_req_i & (cnt_q[synch_sid_i] == '0);

  // State register: per-SID FSM, counters, done pulses and error capture.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NB_SID; s++) begin
        state_q[s] <= ST_IDLE;
        cnt_q[s]   <= '0;
      end
      done_q    <= '0;
      err_q     <= 1'b0;
      err_sid_q <= '0;
    end else begin
      for (int s = 0; s < NB_SID; s++) begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      done_q    <= done_d;
      err_q     <= err_d;
      err_sid_q <= err_sid_d;
    end
  end

  // Next-state: counter arithmetic, FSM transitions and done detection per SID.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    done_d = '0;
    for (int s = 0; s < NB_SID; s++) begin
      logic inc, dec;
      cnt_d[s]   = cnt_q[s];
      state_d[s] = state_q[s];
      inc = issue_acc && (issue_sid_i == TRANS_SID_WIDTH'(s));
      dec = synch_req_i && (synch_sid_i == TRANS_SID_WIDTH'(s)) && (cnt_q[s] != '0);
      // A same-cycle issue and retirement on one SID cancel in the counter.
      if (inc && !dec) cnt_d[s] = cnt_q[s] + CNT_ONE;
      if (dec && !inc) cnt_d[s] = cnt_q[s] - CNT_ONE;
      if (inc) state_d[s] = issue_last_i ? ST_CLOSED : ST_OPEN;
      // A closed transfer that drains completes on this edge and frees the SID.
      if (state_d[s] == ST_CLOSED && cnt_d[s] == '0) begin
        done_d[s]  = 1'b1;
        state_d[s] = ST_IDLE;
      end
    end
  end

  // Next-state: sticky underflow error; a new underflow beats a clear.
  always_comb begin
    err_d     = err_q;
    err_sid_d = err_sid_q;
    if (clear_err_i) begin
      err_d     = 1'b0;
      err_sid_d = '0;
    end
    if (underflow && (!err_q || clear_err_i)) begin
      err_d     = 1'b1;
      err_sid_d = synch_sid_i;
    end
  end

  // Outputs: grant and busy derived from registered state only.
  always_comb begin
    issue_gnt_o = issue_req_i && (cnt_q[issue_sid_i] != CNT_MAX)
                  && (state_q[issue_sid_i] != ST_CLOSED);
    for (int s = 0; s < NB_SID; s++) begin
      busy_o[s] = (state_q[s] != ST_IDLE) || (cnt_q[s] != '0);
    end
  end

  assign trans_done_o = done_q;
  assign err_o        = err_q;
  assign err_sid_o    = err_sid_q;

endmodule

// File: tb/tb_tcdm_synch_tracker.sv
// Self-checking bench for tcdm_synch_tracker: directed scenarios followed by
// random traffic, all compared cycle by cycle against a transaction-level model.
module tb_tcdm_synch_tracker;

  localparam int W      = 2;
  localparam int NB     = 4;
  localparam int MAXCNT = 15;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          issue_req_i = 1'b0;
  logic [W-1:0]  issue_sid_i = '0;
  logic          issue_last_i = 1'b0;
  logic          issue_gnt_o;
  logic          synch_req_i = 1'b0;
  logic [W-1:0]  synch_sid_i = '0;
  logic [NB-1:0] trans_done_o;
  logic [NB-1:0] busy_o;
  logic          err_o;
  logic [W-1:0]  err_sid_o;
  logic          clear_err_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding count plus "transfer open" / "last seen" flags.
  int m_cnt    [NB];
  bit m_open   [NB];
  bit m_closed [NB];
  bit [NB-1:0] m_done;
  bit m_err;
  int m_err_sid;

  tcdm_synch_tracker #(.TRANS_SID_WIDTH(W), .CNT_WIDTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .issue_req_i  (issue_req_i),
    .issue_sid_i  (issue_sid_i),
    .issue_last_i (issue_last_i),
    .issue_gnt_o  (issue_gnt_o),
    .synch_req_i  (synch_req_i),
    .synch_sid_i  (synch_sid_i),
    .trans_done_o (trans_done_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .err_sid_o    (err_sid_o),
    .clear_err_i  (clear_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NB; s++) begin
      m_cnt[s] = 0; m_open[s] = 0; m_closed[s] = 0;
    end
    m_done = '0; m_err = 0; m_err_sid = 0;
  endfunction

  function automatic bit model_gnt(bit req, int sid);
    return req && (m_cnt[sid] != MAXCNT) && !m_closed[sid];
  endfunction

  function automatic logic [NB-1:0] model_busy();
    logic [NB-1:0] b;
    for (int s = 0; s < NB; s++) b[s] = m_open[s] || m_closed[s] || (m_cnt[s] != 0);
    return b;
  endfunction

  function automatic void model_step(bit req, int sid, bit last, bit sreq, int ssid, bit clr);
    bit acc = model_gnt(req, sid);
    bit uf  = sreq && (m_cnt[ssid] == 0);
    int nc [NB];
    for (int s = 0; s < NB; s++) nc[s] = m_cnt[s];
    if (acc) nc[sid] = nc[sid] + 1;
    if (sreq && m_cnt[ssid] > 0) nc[ssid] = nc[ssid] - 1;
    if (acc) begin
      if (last) begin m_closed[sid] = 1; m_open[sid] = 0; end
      else m_open[sid] = 1;
    end
    m_done = '0;
    for (int s = 0; s < NB; s++) begin
      m_cnt[s] = nc[s];
      if (m_closed[s] && nc[s] == 0) begin
        m_done[s] = 1; m_closed[s] = 0; m_open[s] = 0;
      end
    end
    if (uf && (!m_err || clr)) begin
      m_err = 1; m_err_sid = ssid;
    end else if (clr) begin
      m_err = 0; m_err_sid = 0;
    end
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".done"}, 32'(trans_done_o), 32'(m_done));
    check({tag, ".busy"}, 32'(busy_o), 32'(model_busy()));
    check({tag, ".err"}, 32'(err_o), 32'(m_err));
    check({tag, ".err_sid"}, 32'(err_sid_o), 32'(m_err_sid));
  endtask

  // One clock: drive at negedge, check grant, advance model at posedge, check state.
  task automatic cyc(input bit req, input int sid, input bit last,
                     input bit sreq, input int ssid, input bit clr, input string tag);
    @(negedge clk);
    issue_req_i = req; issue_sid_i = W'(sid); issue_last_i = last;
    synch_req_i = sreq; synch_sid_i = W'(ssid); clear_err_i = clr;
    #1 check({tag, ".gnt"}, 32'(issue_gnt_o), 32'(model_gnt(req, sid)));
    @(posedge clk);
    model_step(req, sid, last, sreq, ssid, clr);
    #1 check_regs(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, "idle");
  endtask

  initial begin
    model_reset();
    #12;
    check_regs("reset");
    @(negedge clk) rst_i = 1'b0;

    // SID1: three issues, last on the third, then three retirements.
    for (int i = 0; i < 3; i++) cyc(1, 1, i == 2, 0, 0, 0, "sid1_issue");
    cyc(0, 0, 0, 1, 1, 0, "sid1_synch");
    cyc(0, 0, 0, 1, 1, 0, "sid1_synch");
    cyc(0, 0, 0, 1, 1, 0, "sid1_synch_last");
    check("sid1_done_vec", 32'(trans_done_o), 32'h2);
    idle(1);
    check("sid1_busy_after", 32'(busy_o[1]), 32'h0);

    // SID2: last issue and retirement in the same cycle with cnt2=1.
    cyc(1, 2, 0, 0, 0, 0, "sid2_first");
    cyc(1, 2, 1, 1, 2, 0, "sid2_same_cycle");
    check("sid2_no_done", 32'(trans_done_o), 32'h0);
    cyc(0, 0, 0, 1, 2, 0, "sid2_final");
    check("sid2_done_vec", 32'(trans_done_o), 32'h4);

    // SID0: saturate the counter, then free one slot.
    for (int i = 0; i < MAXCNT; i++) cyc(1, 0, 0, 0, 0, 0, "sid0_fill");
    cyc(1, 0, 0, 0, 0, 0, "sid0_full");
    check("sid0_gnt_full", 32'(issue_gnt_o), 32'h0);
    cyc(0, 0, 0, 1, 0, 0, "sid0_drain1");
    cyc(1, 0, 1, 0, 0, 0, "sid0_close");
    cyc(1, 0, 0, 0, 0, 0, "sid0_closed_gnt");
    for (int i = 0; i < MAXCNT; i++) cyc(0, 0, 0, 1, 0, 0, "sid0_drain");
    check("sid0_done_vec", 32'(trans_done_o), 32'h1);

    // Underflow on SID3, second underflow on SID0 keeps first SID, then clear.
    cyc(0, 0, 0, 1, 3, 0, "uf_sid3");
    check("uf_sid3_errsid", 32'(err_sid_o), 32'h3);
    cyc(0, 0, 0, 1, 0, 0, "uf_sid0");
    check("uf_sticky_sid", 32'(err_sid_o), 32'h3);
    cyc(0, 0, 0, 0, 0, 1, "clear_err");
    check("clear_err_o", 32'(err_o), 32'h0);
    cyc(0, 0, 0, 1, 1, 1, "clear_vs_set");

    // Interleaved SID0/SID1 with back-to-back final retirements.
    cyc(1, 0, 0, 0, 0, 0, "il_a");
    cyc(1, 1, 0, 0, 0, 0, "il_b");
    cyc(1, 0, 1, 1, 1, 0, "il_c");
    cyc(1, 1, 1, 1, 0, 0, "il_d");
    cyc(1, 0, 0, 1, 0, 0, "il_e");
    check("il_done0", 32'(trans_done_o), 32'h1);
    cyc(0, 0, 0, 1, 1, 0, "il_f");
    check("il_done1", 32'(trans_done_o), 32'h2);
    cyc(0, 0, 0, 1, 0, 0, "il_g");

    // Asynchronous reset mid-transfer on SID2.
    cyc(1, 2, 0, 0, 0, 0, "rst_fill");
    cyc(1, 2, 0, 0, 0, 0, "rst_fill");
    @(negedge clk);
    issue_req_i = 1'b1; issue_sid_i = 2'd2; issue_last_i = 1'b0;
    synch_req_i = 1'b0; clear_err_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 model_reset();
    check_regs("async_rst");
    check("async_rst.gnt", 32'(issue_gnt_o), 32'h1);
    issue_req_i = 1'b0;
    @(negedge clk) rst_i = 1'b0;
    cyc(0, 0, 0, 1, 2, 0, "post_rst_uf");
    check("post_rst_err", 32'(err_o), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit req  = ($urandom_range(0, 99) < 60);
      int sid  = $urandom_range(0, NB - 1);
      bit last = ($urandom_range(0, 99) < 25);
      bit sreq = ($urandom_range(0, 99) < 55);
      int ssid = $urandom_range(0, NB - 1);
      bit clr  = ($urandom_range(0, 99) < 4);
      // Keep retirements mostly legal so transfers complete.
      if (sreq && m_cnt[ssid] == 0 && $urandom_range(0, 9) != 0) sreq = 0;
      // A retirement racing an issue into an empty SID is not exercised.
      if (sreq && req && ssid == sid && m_cnt[ssid] == 0) sreq = 0;
      cyc(req, sid, last, sreq, ssid, clr, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
